// File: rtl/fiat_25519_carry_chain_seq.sv
// Sequential carry-propagation stage for radix-2^25.5 limbs of p = 2^255-19: loads 10 accumulators,
// ripples carries one limb per cycle, folds the top carry back as carry*19 and streams out 10 limbs.
// Optional frame/overflow statistics counters are enabled with `define FIAT_CARRY_STATS_EN.
module fiat_25519_carry_chain_seq #(
  parameter int ACC_W   = 64,
  parameter int NLIMB   = 10,
  parameter int CARRY_W = 39,
  parameter int MULC    = 19
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [ACC_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [25:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             err_ovf
`ifdef FIAT_CARRY_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       ovf_cnt
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NLIMB - 1);
  localparam logic [5:0] MULC_F   = 6'(MULC);
  localparam int         PW       = 44;

  typedef enum logic [2:0] {
    S_LOAD,
    S_CARRY,
    S_WRAP,
    S_FIX,
    S_OUT
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [CARRY_W-1:0]   carry_q, carry_d;
  logic                 err_q, err_d;
  logic [ACC_W-1:0]     limb_q [NLIMB];
  logic [ACC_W-1:0]     limb_d [NLIMB];

  logic                 in_fire, out_fire;
  logic                 odd;
  logic [ACC_W:0]       sum;
  logic [ACC_W:0]       shifted;
  logic [ACC_W-1:0]     mask;
  logic [PW-1:0]        prod;

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_data  = limb_q[idx_q][25:0];
  assign err_ovf   = err_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    err_d   = err_q;
    limb_d  = limb_q;

    odd     = idx_q[0];
    sum     = {1'b0, limb_q[idx_q]} + (ACC_W + 1)'(carry_q);
    shifted = odd ? (sum >> 25) : (sum >> 26);
    mask    = odd ? {{(ACC_W - 25){1'b0}}, {25{1'b1}}} : {{(ACC_W - 26){1'b0}}, {26{1'b1}}};
    prod    = PW'(carry_q) * PW'(MULC_F);

    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          limb_d[idx_q] = in_data;
          if (idx_q == 4'd0) err_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            carry_d = '0;
            state_d = S_CARRY;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_CARRY: begin
        limb_d[idx_q] = sum[ACC_W-1:0] & mask;
        carry_d       = shifted[CARRY_W-1:0];
        // Carry bits above CARRY_W are dropped; flag the frame as corrupt.
        if (|shifted[ACC_W:CARRY_W]) err_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = 4'd0;
          state_d = S_WRAP;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_WRAP: begin
        limb_d[0] = limb_q[0] + ACC_W'(prod);
        state_d   = S_FIX;
      end
      S_FIX: begin
        limb_d[1] = limb_q[1] + (limb_q[0] >> 26);
        limb_d[0] = limb_q[0] & {{(ACC_W - 26){1'b0}}, {26{1'b1}}};
        idx_d     = 4'd0;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (out_fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_LOAD;
      idx_q   <= 4'd0;
      carry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the limb buffer is not reset; every entry is written in LOAD before it is ever read.
  always_ff @(posedge ap_clk) begin
    limb_q <= limb_d;
  end

`ifdef FIAT_CARRY_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  ovf_cnt_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      frame_cnt_q <= 16'd0;
      ovf_cnt_q   <= 8'd0;
    end else if (out_fire && out_last) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_q && (ovf_cnt_q != 8'hFF)) ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fiat_25519_carry_chain_seq.sv
// Self-checking bench for fiat_25519_carry_chain_seq: directed frames plus randomized frames,
// compared against an arithmetic reference of the carry/fold reduction.
module tb_fiat_25519_carry_chain_seq;

  localparam int NL = 10;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        err_ovf;
`ifdef FIAT_CARRY_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  ovf_cnt;
`endif

  fiat_25519_carry_chain_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .err_ovf   (err_ovf)
`ifdef FIAT_CARRY_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc = cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] frame_in [NL];
  logic [25:0] exp_out  [NL];
  logic        exp_ovf;
  logic        prev_ovf;
  int          t_last_in;
  bit          gaps;
  bit          rand_ready;
  int          stall_at;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: ripple each limb with its own radix, drop carry bits past 39, fold carry*19, fix limb 0.
  function automatic void ref_model();
    logic [64:0] s, c, pw;
    logic [64:0] l [NL];
    c       = '0;
    exp_ovf = 1'b0;
    for (int i = 0; i < NL; i++) begin
      pw   = 65'd1 << ((i % 2 == 1) ? 25 : 26);
      s    = {1'b0, frame_in[i]} + c;
      l[i] = s % pw;
      c    = s / pw;
      if (c >= (65'd1 << 39)) begin
        exp_ovf = 1'b1;
        c       = c % (65'd1 << 39);
      end
    end
    l[0] = l[0] + c * 65'd19;
    l[1] = l[1] + l[0] / (65'd1 << 26);
    l[0] = l[0] % (65'd1 << 26);
    for (int i = 0; i < NL; i++) exp_out[i] = l[i][25:0];
  endfunction

  task automatic send_frame();
    int to;
    check("err_sticky", 64'(err_ovf), 64'(prev_ovf));
    for (int i = 0; i < NL; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(posedge ap_clk); #1;
      end
      in_data  = frame_in[i];
      in_valid = 1'b1;
      to = 0;
      while (!in_ready && to < 100) begin
        @(posedge ap_clk); #1;
        to++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge ap_clk); #1;
      if (i == 0) check("err_clear_first_beat", 64'(err_ovf), 64'd0);
    end
    in_valid  = 1'b0;
    t_last_in = cyc;
  endtask

  task automatic recv_frame();
    int to;
    to = 0;
    while (!out_valid && to < 100) begin
      @(posedge ap_clk); #1;
      to++;
    end
    check("out_valid_rise", 64'(out_valid), 64'd1);
    if (!out_valid) return;
    check("latency", 64'(cyc - t_last_in), 64'd12);
    for (int k = 0; k < NL; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge ap_clk); #1;
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", 64'(out_data), 64'(exp_out[k]));
          check("stall_in_ready", 64'(in_ready), 64'd0);
        end
      end else if (rand_ready) begin
        to = 0;
        while ($urandom_range(2) == 0 && to < 4) begin
          out_ready = 1'b0;
          @(posedge ap_clk); #1;
          to++;
        end
      end
      out_ready = 1'b1;
      check("out_valid", 64'(out_valid), 64'd1);
      check($sformatf("limb%0d", k), 64'(out_data), 64'(exp_out[k]));
      check("out_last", 64'(out_last), 64'(k == NL - 1));
      check("err_ovf", 64'(err_ovf), 64'(exp_ovf));
      check("in_ready_busy", 64'(in_ready), 64'd0);
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b0;
    check("out_valid_after", 64'(out_valid), 64'd0);
    check("in_ready_after", 64'(in_ready), 64'd1);
    prev_ovf = exp_ovf;
  endtask

  task automatic run_frame();
    ref_model();
    send_frame();
    recv_frame();
  endtask

  task automatic set_zero();
    for (int i = 0; i < NL; i++) frame_in[i] = 64'd0;
  endtask

  task automatic pulse_reset();
    @(posedge ap_clk); #3;
    ap_rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_err_ovf", 64'(err_ovf), 64'd0);
    @(posedge ap_clk); #3;
    ap_rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    prev_ovf = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  initial begin
    int to;
    ap_rst_n   = 1'b0;
    in_valid   = 1'b0;
    in_data    = 64'd0;
    out_ready  = 1'b0;
    prev_ovf   = 1'b0;
    gaps       = 1'b0;
    rand_ready = 1'b0;
    stall_at   = -1;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_last", 64'(out_last), 64'd0);
    check("reset_err_ovf", 64'(err_ovf), 64'd0);
    repeat (2) @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // All-zero frame.
    set_zero();
    run_frame();

    // Single carry out of limb 0.
    set_zero();
    frame_in[0] = 64'd1 << 26;
    run_frame();

    // Top carry folded back as 19.
    set_zero();
    frame_in[0] = (64'd1 << 26) - 64'd1;
    frame_in[9] = 64'd1 << 25;
    run_frame();

    // Saturated limbs lose carry bits.
    for (int i = 0; i < NL; i++) frame_in[i] = '1;
    run_frame();

    // Output stall on the third beat.
    set_zero();
    frame_in[0] = 64'd1 << 26;
    stall_at = 2;
    run_frame();
    stall_at = -1;

    // Reset while the carry chain is running, then a clean frame.
    for (int i = 0; i < NL; i++) frame_in[i] = {$urandom, $urandom};
    send_frame();
    repeat (3) @(posedge ap_clk);
    pulse_reset();
    set_zero();
    frame_in[0] = (64'd1 << 26) - 64'd1;
    frame_in[9] = 64'd1 << 25;
    run_frame();

    // Reset while streaming out.
    for (int i = 0; i < NL; i++) frame_in[i] = 64'(i + 1) << 30;
    send_frame();
    to = 0;
    while (!out_valid && to < 100) begin
      @(posedge ap_clk); #1;
      to++;
    end
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    pulse_reset();

    // Randomized frames with input gaps and output back-pressure.
    gaps       = 1'b1;
    rand_ready = 1'b1;
    for (int f = 0; f < 14; f++) begin
      for (int i = 0; i < NL; i++) begin
        case ($urandom_range(3))
          0: frame_in[i] = 64'($urandom_range(0, (1 << 26) - 1));
          1: frame_in[i] = {$urandom, $urandom};
          2: frame_in[i] = (i % 2 == 1) ? ((64'd1 << 25) - 64'd1) : ((64'd1 << 26) - 64'd1);
          default: frame_in[i] = {14'd0, $urandom_range(0, 262143), $urandom} & ((64'd1 << 50) - 64'd1);
        endcase
      end
      run_frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
